// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_1rw1r_clr slice: sweep states and lane merge.
// The merge is sized for the widest supported word and truncated by each caller.
package sram_pkg;

    typedef enum logic {
        SRAM_IDLE,
        SRAM_CLEAR
    } sweep_state_e;

    localparam int SRAM_MAX_DW    = 256;
    localparam int SRAM_MAX_LANES = 64;

    // Lane-wise merge: bits whose lane mask is set come from new_data, the rest from old_data.
    function automatic logic [SRAM_MAX_DW-1:0] lane_merge(
        input logic [SRAM_MAX_DW-1:0]    old_data,
        input logic [SRAM_MAX_DW-1:0]    new_data,
        input logic [SRAM_MAX_LANES-1:0] mask,
        input int                        lane_w
    );
        logic [SRAM_MAX_DW-1:0] merged;
        int lane;
        merged = old_data;
        for (int b = 0; b < SRAM_MAX_DW; b++) begin
            lane = b / lane_w;
            if (lane < SRAM_MAX_LANES) begin
                if (mask[lane[5:0]]) begin
                    merged[b] = new_data[b];
                end
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Sweep engine for sram_1rw1r_clr: zeroes one entry per cycle after reset or a flush request.
// busy is registered and doubles as the clear write enable.
module sram_clear_fsm
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  clr,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RAM_DEPTH - 1);

    sweep_state_e          state;
    logic [ADDR_WIDTH-1:0] idx;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state <= SRAM_CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                SRAM_IDLE: begin
                    if (clr) begin
                        state <= SRAM_CLEAR;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SRAM_CLEAR: begin
                    // The last entry is zeroed on the same edge that drops busy.
                    if (idx == LAST_IDX) begin
                        state <= SRAM_IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= SRAM_CLEAR;
                    idx   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we   = (state == SRAM_CLEAR);
    assign clr_addr = idx;

endmodule

// File: rtl/sram_1rw1r_clr.sv
// Behavioural 1RW+1R SRAM with per-lane write mask and a self-clearing sweep engine.
// Optional macro SRAM_WRITE_BYPASS_EN forwards a pending port-0 write to both read ports.
module sram_1rw1r_clr
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter int WMASK_WIDTH = 4
) (
    input  logic                   clk0,
    input  logic                   rst0_n,
    input  logic                   clr,
    output logic                   busy,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1
);

    localparam int LANE_W = DATA_WIDTH / WMASK_WIDTH;

    logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

    logic                   web0_reg;
    logic [WMASK_WIDTH-1:0] wmask0_reg;
    logic [ADDR_WIDTH-1:0]  addr0_reg;
    logic [DATA_WIDTH-1:0]  din0_reg;
    logic [ADDR_WIDTH-1:0]  addr1_reg;

    logic                   clr_we;
    logic [ADDR_WIDTH-1:0]  clr_addr;
    logic                   addr0_ok;
    logic                   addr1_ok;
    logic [DATA_WIDTH-1:0]  rd0;
    logic [DATA_WIDTH-1:0]  rd1;
    logic [DATA_WIDTH-1:0]  commit_data;

    sram_clear_fsm #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_clear_fsm (
        .clk0    (clk0),
        .rst0_n  (rst0_n),
        .clr     (clr),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // On a flush edge the pending write still commits, but is retired so it
    // cannot replay over the freshly cleared array once the sweep finishes.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            web0_reg   <= 1'b1;
            wmask0_reg <= '0;
            addr0_reg  <= '0;
            din0_reg   <= '0;
            addr1_reg  <= '0;
        end else if (!busy) begin
            if (clr) begin
                web0_reg <= 1'b1;
            end else begin
                if (!csb0) begin
                    web0_reg   <= web0;
                    wmask0_reg <= wmask0;
                    addr0_reg  <= addr0;
                    din0_reg   <= din0;
                end
                if (!csb1) begin
                    addr1_reg <= addr1;
                end
            end
        end
    end

    assign addr0_ok    = (32'(addr0_reg) < RAM_DEPTH);
    assign addr1_ok    = (32'(addr1_reg) < RAM_DEPTH);
    assign rd0         = addr0_ok ? mem[addr0_reg] : '0;
    assign rd1         = addr1_ok ? mem[addr1_reg] : '0;
    assign commit_data = DATA_WIDTH'(lane_merge(SRAM_MAX_DW'(rd0), SRAM_MAX_DW'(din0_reg),
                                                SRAM_MAX_LANES'(wmask0_reg), LANE_W));

    always_ff @(posedge clk0) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (rst0_n && !busy && !web0_reg && addr0_ok) begin
            mem[addr0_reg] <= commit_data;
        end
    end

    always_comb begin
        dout0 = '0;
        dout1 = '0;
        if (!busy) begin
            dout0 = rd0;
            dout1 = rd1;
`ifdef SRAM_WRITE_BYPASS_EN
            if (!web0_reg && addr0_ok) begin
                dout0 = commit_data;
                if (addr1_reg == addr0_reg) begin
                    dout1 = commit_data;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_1rw1r_clr.sv
// Scoreboard bench for sram_1rw1r_clr: sweep timing, masked writes, collisions, flush and reset mid-sweep.
module tb_sram_1rw1r_clr;

    logic        clk0 = 1'b0;
    logic        rst0_n = 1'b0;
    logic        clr = 1'b0;
    logic        busy;
    logic        csb0 = 1'b1;
    logic        web0 = 1'b1;
    logic [3:0]  wmask0 = '0;
    logic [7:0]  addr0 = '0;
    logic [31:0] din0 = '0;
    logic [31:0] dout0;
    logic        csb1 = 1'b1;
    logic [7:0]  addr1 = '0;
    logic [31:0] dout1;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] expQ[$];
    logic [31:0] model[256];

    sram_1rw1r_clr dut (
        .clk0  (clk0),
        .rst0_n(rst0_n),
        .clr   (clr),
        .busy  (busy),
        .csb0  (csb0),
        .web0  (web0),
        .wmask0(wmask0),
        .addr0 (addr0),
        .din0  (din0),
        .dout0 (dout0),
        .csb1  (csb1),
        .addr1 (addr1),
        .dout1 (dout1)
    );

    always #5 clk0 = ~clk0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic compareNext(input string tag, input logic [31:0] actual);
        if (expQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected nothing (scoreboard empty)", tag, actual);
        end else begin
            checkOutput(tag, actual, expQ.pop_front());
        end
    endtask

    function automatic logic [31:0] byteMerge(input logic [31:0] oldW, input logic [31:0] newW, input logic [3:0] m);
        logic [31:0] r;
        for (int lane = 0; lane < 4; lane++) begin
            r[lane*8 +: 8] = m[lane] ? newW[lane*8 +: 8] : oldW[lane*8 +: 8];
        end
        return r;
    endfunction

    // Called at a negedge; holds the request across one posedge and returns at the next negedge.
    task automatic applyStimulus(input logic doWrite, input logic [3:0] m, input logic [7:0] a0,
                                 input logic [31:0] d0, input logic doRead, input logic [7:0] a1);
        csb0   = !doWrite;
        web0   = !doWrite;
        wmask0 = m;
        addr0  = a0;
        din0   = d0;
        csb1   = !doRead;
        addr1  = a1;
        @(posedge clk0);
        @(negedge clk0);
        csb0 = 1'b1;
        web0 = 1'b1;
        csb1 = 1'b1;
    endtask

    task automatic writeWord(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
`ifdef SRAM_WRITE_BYPASS_EN
        expQ.push_back(byteMerge(model[a], d, m));
`else
        expQ.push_back(model[a]);
`endif
        applyStimulus(1'b1, m, a, d, 1'b0, 8'h00);
        compareNext("wrPreCommit", dout0);
        model[a] = byteMerge(model[a], d, m);
        expQ.push_back(model[a]);
        @(negedge clk0);
        compareNext("wrPostCommit", dout0);
    endtask

    task automatic readWord1(input logic [7:0] a);
        expQ.push_back(model[a]);
        applyStimulus(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, a);
        compareNext("rdPort1", dout1);
    endtask

    // Called at a negedge with busy high; counts posedges until busy drops.
    task automatic waitBusyLow(input string tag, input int startCnt, input int expected);
        int cnt;
        cnt = startCnt;
        while (busy && cnt < 1000) begin
            @(posedge clk0);
            cnt++;
            @(negedge clk0);
        end
        checkOutput(tag, 32'(cnt), 32'(expected));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = '0;

        // Reset state
        @(negedge clk0);
        @(negedge clk0);
        checkOutput("rstBusy", {31'b0, busy}, 32'd1);
        checkOutput("rstDout0", dout0, 32'h0);
        checkOutput("rstDout1", dout1, 32'h0);
        rst0_n = 1'b1;
        waitBusyLow("initSweepLen", 0, 256);

        readWord1(8'hFF);

        writeWord(8'h12, 32'hDEADBEEF, 4'b1111);
        readWord1(8'h12);
        writeWord(8'h12, 32'h11223344, 4'b0101);
        readWord1(8'h12);
        checkOutput("maskedValue", model[8'h12], 32'hDE22BE44);
        writeWord(8'h12, 32'h55555555, 4'b0000);
        readWord1(8'h12);

        // Same-edge write and read of one address
`ifdef SRAM_WRITE_BYPASS_EN
        expQ.push_back(32'hCAFEF00D);
`else
        expQ.push_back(model[8'h12]);
`endif
        applyStimulus(1'b1, 4'hF, 8'h12, 32'hCAFEF00D, 1'b1, 8'h12);
        compareNext("collPre", dout1);
        model[8'h12] = 32'hCAFEF00D;
        expQ.push_back(model[8'h12]);
        @(negedge clk0);
        compareNext("collPost", dout1);

        // Fill low entries, then flush
        for (int i = 0; i < 16; i++) begin
            writeWord(8'(i), 32'hA5000000 | 32'(i * 32'h01010101), 4'hF);
        end
        readWord1(8'h05);
        readWord1(8'h0F);

        clr = 1'b1;
        @(posedge clk0);
        @(negedge clk0);
        clr = 1'b0;
        checkOutput("clrBusy", {31'b0, busy}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'h03; din0 = 32'hFFFFFFFF;
            csb1 = 1'b0; addr1 = 8'h03;
            @(posedge clk0);
            @(negedge clk0);
            checkOutput("busyDout0", dout0, 32'h0);
            checkOutput("busyDout1", dout1, 32'h0);
        end
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
        waitBusyLow("clrSweepLen", 3, 256);
        for (int i = 0; i < 256; i++) model[i] = '0;
        for (int i = 0; i < 16; i++) readWord1(8'(i));

        // Reset in the middle of a sweep restarts it
        writeWord(8'h20, 32'h12345678, 4'hF);
        clr = 1'b1;
        @(posedge clk0);
        @(negedge clk0);
        clr = 1'b0;
        repeat (100) @(negedge clk0);
        rst0_n = 1'b0;
        @(negedge clk0);
        @(negedge clk0);
        checkOutput("midRstBusy", {31'b0, busy}, 32'd1);
        rst0_n = 1'b1;
        waitBusyLow("restartSweepLen", 0, 256);
        for (int i = 0; i < 256; i++) model[i] = '0;
        readWord1(8'h20);
        readWord1(8'h12);

        if (expQ.size() != 0) begin
            checkOutput("scoreboardDrain", 32'(expQ.size()), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
